// File: rtl/raw_frame_seq.sv
// rtl/raw_frame_seq.sv - raw Bayer frame sequencer feeding the RAW2RGB debayer
// Tracks x/y of each accepted pixel, gates frames on iEN and flags mid-frame SOF.
module raw_frame_seq #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int CNT_W    = 16,
  parameter int DATA_W   = 12
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEN,
  input  logic [1:0]        iPhase,
  input  logic              iSOF,
  input  logic              iDval,
  input  logic [DATA_W-1:0] iData,
  output logic [DATA_W-1:0] oData,
  output logic              oDval,
  output logic              oX_Cont,
  output logic              oY_Cont,
  output logic              oSOF,
  output logic              oEOL,
  output logic              oEOF,
  output logic              oFrameErr,
  output logic              oBusy,
  output logic [CNT_W-1:0]  oFrameCnt
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   x, y, x_nxt, y_nxt, px, py, cnt_nxt;
  logic [1:0]         shadow, sh_nxt;
  logic               emit, restart, err, eol, eof;

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    sh_nxt    = shadow;
    cnt_nxt   = oFrameCnt;
    emit      = 1'b0;
    restart   = 1'b0;
    err       = 1'b0;
    px        = x;
    py        = y;
    case (state)
      IDLE: begin
        if (iEN) state_nxt = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!iEN) begin
          state_nxt = IDLE;
        end else if (iDval && iSOF) begin
          emit      = 1'b1;
          restart   = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (iDval) begin
          emit = 1'b1;
          if (iSOF) begin
            restart = 1'b1;
            err     = (x != '0) || (y != '0);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A restart (first SOF or sync error) re-anchors this pixel at (0,0) with the new phase
    if (restart) begin
      px     = '0;
      py     = '0;
      sh_nxt = iPhase;
    end

    eol = emit && (px == X_LAST);
    eof = eol && (py == Y_LAST);

    if (emit) begin
      if (eof) begin
        x_nxt     = '0;
        y_nxt     = '0;
        cnt_nxt   = oFrameCnt + CNT_W'(1);
        state_nxt = iEN ? WAIT_SOF : IDLE;
      end else if (eol) begin
        x_nxt = '0;
        y_nxt = py + CNT_W'(1);
      end else begin
        x_nxt = px + CNT_W'(1);
        y_nxt = py;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      shadow    <= 2'b00;
      oFrameCnt <= '0;
      oData     <= '0;
      oDval     <= 1'b0;
      oX_Cont   <= 1'b0;
      oY_Cont   <= 1'b0;
      oSOF      <= 1'b0;
      oEOL      <= 1'b0;
      oEOF      <= 1'b0;
      oFrameErr <= 1'b0;
    end else begin
      state     <= state_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      shadow    <= sh_nxt;
      oFrameCnt <= cnt_nxt;
      oDval     <= emit;
      oSOF      <= restart;
      oEOL      <= eol;
      oEOF      <= eof;
      oFrameErr <= err;
      if (emit) begin
        oData   <= iData;
        oX_Cont <= px[0] ^ sh_nxt[0];
        oY_Cont <= py[0] ^ sh_nxt[1];
      end
    end
  end

  assign oBusy = (state == ACTIVE);

endmodule

// File: tb/tb_raw_frame_seq.sv
// tb/tb_raw_frame_seq.sv - self-checking bench for raw_frame_seq
// Pixel-index reference model plus directed frame scenarios and a random soak.
module tb_raw_frame_seq;

  localparam int H      = 8;
  localparam int V      = 4;
  localparam int CNT_W  = 16;
  localparam int DATA_W = 12;

  logic              iCLK = 1'b0;
  logic              iRST = 1'b1;
  logic              iEN = 1'b0;
  logic [1:0]        iPhase = 2'b00;
  logic              iSOF = 1'b0;
  logic              iDval = 1'b0;
  logic [DATA_W-1:0] iData = '0;
  logic [DATA_W-1:0] oData;
  logic              oDval, oX_Cont, oY_Cont, oSOF, oEOL, oEOF, oFrameErr, oBusy;
  logic [CNT_W-1:0]  oFrameCnt;

  raw_frame_seq #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iPhase(iPhase), .iSOF(iSOF),
    .iDval(iDval), .iData(iData), .oData(oData), .oDval(oDval),
    .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oSOF(oSOF), .oEOL(oEOL),
    .oEOF(oEOF), .oFrameErr(oFrameErr), .oBusy(oBusy), .oFrameCnt(oFrameCnt)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: mode 0=idle 1=waiting for SOF 2=in frame; pix is the linear index in the frame
  int                m_mode, m_pix, m_fcnt;
  logic [1:0]        m_ph;
  logic              e_dval, e_x, e_y, e_sof, e_eol, e_eof, e_err, e_busy;
  logic [DATA_W-1:0] e_data;

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      m_mode = 0; m_pix = 0; m_fcnt = 0; m_ph = 2'b00;
      e_dval = 0; e_x = 0; e_y = 0; e_sof = 0; e_eol = 0; e_eof = 0; e_err = 0;
      e_busy = 0; e_data = '0;
    end else begin
      automatic bit accept = 0;
      automatic bit restart = 0;
      automatic bit err = 0;
      e_dval = 0; e_sof = 0; e_eol = 0; e_eof = 0; e_err = 0;
      if (m_mode == 0) begin
        if (iEN) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!iEN) m_mode = 0;
        else if (iDval && iSOF) begin accept = 1; restart = 1; m_mode = 2; end
      end else if (iDval) begin
        accept = 1;
        if (iSOF) begin restart = 1; err = (m_pix != 0); end
      end
      if (restart) begin m_pix = 0; m_ph = iPhase; end
      if (accept) begin
        e_dval = 1;
        e_data = iData;
        e_x    = ((m_pix % H) % 2 == 1) ^ m_ph[0];
        e_y    = ((m_pix / H) % 2 == 1) ^ m_ph[1];
        e_sof  = restart;
        e_err  = err;
        e_eol  = (m_pix % H) == H - 1;
        e_eof  = m_pix == H * V - 1;
        m_pix++;
        if (m_pix == H * V) begin
          m_pix  = 0;
          m_fcnt = (m_fcnt + 1) % (1 << CNT_W);
          m_mode = iEN ? 1 : 0;
        end
      end
      e_busy = (m_mode == 2);
    end
  end

  // Observation counters for the hand-computed expectations
  int                dval_cnt = 0, eol_cnt = 0, eof_cnt = 0, err_cnt = 0;
  logic [DATA_W-1:0] first_data, last_data;
  logic              sof_x, sof_y, sof_err;
  bit                seen_first = 0;

  always @(negedge iCLK) begin
    if (!iRST) begin
      chk("oDval", oDval, e_dval);
      chk("oData", oData, e_data);
      chk("oSOF", oSOF, e_sof);
      chk("oEOL", oEOL, e_eol);
      chk("oEOF", oEOF, e_eof);
      chk("oFrameErr", oFrameErr, e_err);
      chk("oBusy", oBusy, e_busy);
      chk("oFrameCnt", oFrameCnt, m_fcnt);
      if (e_dval) begin
        chk("oX_Cont", oX_Cont, e_x);
        chk("oY_Cont", oY_Cont, e_y);
      end
      if (oDval) begin
        dval_cnt++;
        last_data = oData;
        if (!seen_first) begin first_data = oData; seen_first = 1; end
        if (oEOL) eol_cnt++;
        if (oEOF) eof_cnt++;
        if (oFrameErr) err_cnt++;
        if (oSOF) begin sof_x = oX_Cont; sof_y = oY_Cont; sof_err = oFrameErr; end
      end
    end
  end

  int pat = 0;

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic clr();
    dval_cnt = 0; eol_cnt = 0; eof_cnt = 0; err_cnt = 0; seen_first = 0;
  endtask

  // n valid pixels on a 4-on/4-off pattern; SOF on pixel sof_idx, iEN dropped at en_off_idx
  task automatic send(input int n, input int sof_idx, input int base, input int en_off_idx);
    int i;
    i = 0;
    while (i < n) begin
      if (pat % 8 < 4) begin
        if (i == en_off_idx) iEN = 1'b0;
        iDval = 1'b1;
        iSOF  = (i == sof_idx);
        iData = DATA_W'(base + i);
        i++;
      end else begin
        iDval = 1'b0;
        iSOF  = 1'($urandom_range(0, 1));
        iData = DATA_W'($urandom);
      end
      pat++;
      cyc();
    end
    iDval = 1'b0;
    iSOF  = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    chk("reset_oDval", oDval, 0);
    chk("reset_oFrameCnt", oFrameCnt, 0);
    chk("reset_oBusy", oBusy, 0);
    iRST = 1'b0;

    // 1: plain frame, phase 0
    iEN = 1'b1; iPhase = 2'b00;
    cyc();
    clr();
    send(32, 0, 0, -1);
    repeat (3) cyc();
    chk("t1_dval_cnt", dval_cnt, 32);
    chk("t1_eol_cnt", eol_cnt, 4);
    chk("t1_eof_cnt", eof_cnt, 1);
    chk("t1_last_data", last_data, 31);
    chk("t1_frame_cnt", oFrameCnt, 1);

    // 2: phase 3 latched at SOF, changed mid-frame
    iPhase = 2'b11;
    clr();
    send(1, 0, 40, -1);
    iPhase = 2'b00;
    send(31, -1, 41, -1);
    repeat (3) cyc();
    chk("t2_sof_x", sof_x, 1);
    chk("t2_sof_y", sof_y, 1);
    chk("t2_frame_cnt", oFrameCnt, 2);

    // 3: pixels before SOF are dropped
    clr();
    send(5, -1, 90, -1);
    repeat (2) cyc();
    chk("t3_no_dval", dval_cnt, 0);
    send(32, 0, 100, -1);
    repeat (3) cyc();
    chk("t3_first_data", first_data, 100);
    chk("t3_frame_cnt", oFrameCnt, 3);

    // 4: SOF at pixel 13 is a sync error and restarts the frame
    clr();
    send(13, 0, 200, -1);
    send(32, 0, 300, -1);
    repeat (3) cyc();
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_err_sof_x", sof_x, 0);
    chk("t4_err_flag", sof_err, 1);
    chk("t4_frame_cnt", oFrameCnt, 4);

    // 5: iEN dropped mid-frame, frame still completes
    clr();
    send(32, 0, 400, 10);
    repeat (3) cyc();
    chk("t5_eof_cnt", eof_cnt, 1);
    chk("t5_frame_cnt", oFrameCnt, 5);
    chk("t5_busy", oBusy, 0);
    clr();
    send(1, 0, 500, -1);
    repeat (3) cyc();
    chk("t5_no_dval", dval_cnt, 0);

    // 6: async reset in the middle of a frame
    iEN = 1'b1;
    cyc();
    send(20, 0, 600, -1);
    iDval = 1'b1; iSOF = 1'b0; iData = 12'h7FF;
    #2 iRST = 1'b1;
    #1;
    chk("t6_oDval", oDval, 0);
    chk("t6_oData", oData, 0);
    chk("t6_oFrameCnt", oFrameCnt, 0);
    chk("t6_oEOL", oEOL, 0);
    chk("t6_oBusy", oBusy, 0);
    cyc(); cyc();
    iRST = 1'b0; iDval = 1'b0; iEN = 1'b0;
    clr();
    send(4, 0, 700, -1);
    repeat (2) cyc();
    chk("t6_no_dval", dval_cnt, 0);
    iEN = 1'b1;
    cyc();
    send(32, 0, 800, -1);
    repeat (3) cyc();
    chk("t6_frame_cnt", oFrameCnt, 1);

    // Random soak against the model
    for (int k = 0; k < 2000; k++) begin
      iEN    = ($urandom_range(0, 19) != 0);
      iPhase = 2'($urandom);
      iDval  = ($urandom_range(0, 3) != 0);
      iSOF   = ($urandom_range(0, 39) == 0);
      iData  = DATA_W'($urandom);
      cyc();
    end
    iDval = 1'b0; iSOF = 1'b0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raw_frame_seq.md
Name: raw_frame_seq

Overview:
Frame sequencer placed directly ahead of the RAW2RGB debayer. It accepts a raw Bayer pixel stream with a start-of-frame marker and tracks the x/y position of every pixel. It registers the pixels and drives RAW2RGB's data-valid and X/Y parity inputs (iDval, iX_Cont, iY_Cont). It also gates frames on an enable, applies a per-frame Bayer phase, and flags frame-sync errors.

Parameters:
H_ACTIVE, 1920, active pixels per line
V_ACTIVE, 1080, active lines per frame
CNT_W, 16, width of x/y/frame counters
DATA_W, 12, raw pixel width

Ports:
iCLK  in  1  clock; all logic on rising edge
iRST  in  1  asynchronous active-high reset
iEN  in  1  frame enable; sampled only at frame boundaries
iPhase  in  2  Bayer phase; bit0 XORs x parity, bit1 XORs y parity
iSOF  in  1  start-of-frame; qualified by iDval; marks pixel (0,0)
iDval  in  1  input pixel valid
iData  in  DATA_W  raw pixel
oData  out  DATA_W  registered pixel, to RAW2RGB iData
oDval  out  1  to RAW2RGB iDval
oX_Cont  out  1  to RAW2RGB iX_Cont
oY_Cont  out  1  to RAW2RGB iY_Cont
oSOF  out  1  with oDval: first pixel of frame
oEOL  out  1  with oDval: last pixel of line
oEOF  out  1  with oDval: last pixel of frame
oFrameErr  out  1  one-cycle pulse on sync error
oBusy  out  1  high in ACTIVE
oFrameCnt  out  CNT_W  completed frames; wraps at 2^CNT_W

Behaviour:
- Reset (async, iRST=1): state=IDLE. x, y, oFrameCnt and phase shadow = 0. All outputs 0.
- States: IDLE, WAIT_SOF, ACTIVE.
- IDLE: iEN=1 -> WAIT_SOF next cycle. Input pixels are dropped.
- WAIT_SOF: iEN=0 -> IDLE. Pixels are dropped until iDval&iSOF. On that pixel: latch iPhase into the shadow, go to ACTIVE, emit the pixel as (0,0).
- ACTIVE: each iDval pixel is emitted at current (x,y), then x increments. At x=H_ACTIVE-1: x<=0, y increments.
- Last pixel (x=H_ACTIVE-1, y=V_ACTIVE-1): x,y<=0 and oFrameCnt increments. Next state is WAIT_SOF if iEN=1, else IDLE.
- iEN deasserted mid-frame: the current frame completes; iEN is only checked at frame end.
- Sync error: iDval&iSOF in ACTIVE at any position other than (0,0):
  - oFrameErr pulses (aligned with that pixel's oDval).
  - Frame restarts: the pixel is emitted as (0,0) with oSOF=1, the phase shadow reloads, oFrameCnt is unchanged.
- Missing iSOF at an expected frame start (state WAIT_SOF): pixels are dropped silently, no error.
- iDval=0: counters hold; oDval=0; oData holds its last value.
- Latency: exactly 1 cycle from input to oData/oDval/oX_Cont/oY_Cont/oSOF/oEOL/oEOF.
- oX_Cont = x[0]^shadow[0]; oY_Cont = y[0]^shadow[1]. Computed from the pre-increment position of the emitted pixel.
- iPhase changes mid-frame have no effect until the next accepted SOF.
- oSOF/oEOL/oEOF/oFrameErr are 0 whenever oDval=0. oEOF implies oEOL.
- oBusy = (state==ACTIVE), registered.

Test Plan:
(Bench uses H_ACTIVE=8, V_ACTIVE=4, CNT_W=16 and a 4-on/4-off valid pattern.)
1. Reset, iEN=1, iPhase=0, iSOF with first pixel, 32 pixels iData=0..31 -> 32 oDval pulses 1 cycle later, oData=0..31. oX_Cont toggles 0,1,… per pixel; oY_Cont=0,1,0,1 per line. oEOL on pixels 7,15,23,31; oEOF on 31; oFrameCnt=1.
2. iPhase=2'b11 latched at SOF, then changed to 0 mid-frame -> oX_Cont=1 at x=0 and oY_Cont=1 at y=0 for the whole frame. The new phase applies only from the next SOF.
3. iEN=1, 5 pixels without iSOF, then SOF -> the 5 pixels produce no oDval; the first output is oData of the SOF pixel with oSOF=1.
4. iSOF asserted at pixel 13 of a frame -> oFrameErr=1 and oSOF=1 on that output. It is treated as (0,0) with oX_Cont=0; oFrameCnt unchanged; 32 further pixels complete the frame.
5. iEN dropped at pixel 10 -> the frame completes to oEOF, oFrameCnt increments, state goes to IDLE. A following SOF pixel produces no oDval.
6. iRST pulsed during pixel 20 -> all outputs 0 immediately (async). After release: IDLE, oFrameCnt=0, no output until iEN and a new SOF.
